// File: rtl/fruit_pkg.sv
// Shared fruit-game constants and the arming state type.
// Used by the collision detector and the fruit block.
package fruit_pkg;

  localparam int NUM_OF_FRUITS = 5;
  localparam int ARM_FRAMES    = 6;
  localparam int EATEN_MAX     = 7;

  typedef enum logic {
    WAIT_ARM = 1'b0,
    ACTIVE   = 1'b1
  } arm_state_e;

endpackage

// File: rtl/fruit_hit_cell.sv
// Per-fruit hit tracker: issues one registered pulse for the first hit of each frame.
module fruit_hit_cell (
  input  logic clk,
  input  logic reset,
  input  logic sof_i,
  input  logic hit_i,
  output logic fire_o,
  output logic pulse_o
);

  logic flag_q, flag_d;
  logic pulse_q;

  // A hit coinciding with start-of-frame belongs to the new frame.
  always_comb begin
    fire_o = hit_i & (sof_i | ~flag_q);
    flag_d = sof_i ? hit_i : (flag_q | hit_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flag_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      flag_q  <= flag_d;
      pulse_q <= fire_o;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/fruit_collision_detector.sv
// Monkey/fruit collision detector: arms after a number of frames, then pulses
// once per fruit per frame on overlap and keeps a saturating eaten count.
//   state    | meaning
//   WAIT_ARM | counting frame pulses after reset, hits ignored
//   ACTIVE   | detection enabled until reset
module fruit_collision_detector
  import fruit_pkg::*;
#(
  parameter int NUM_OF_FRUITS = fruit_pkg::NUM_OF_FRUITS,
  parameter int ARM_FRAMES    = fruit_pkg::ARM_FRAMES
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     startOfFrame,
  input  logic                     monkeyDrawingRequest,
  input  logic [NUM_OF_FRUITS-1:0] fruitDrawingRequest,
  input  logic [NUM_OF_FRUITS-1:0] drawFruit,
  output logic [NUM_OF_FRUITS-1:0] monkeyCollision,
  output logic [2:0]               eatenCount,
  output logic                     armed
);

  localparam int CNT_W = $clog2(ARM_FRAMES + 1);
  localparam int SUM_W = $clog2(NUM_OF_FRUITS + EATEN_MAX + 1);

  arm_state_e         state_q;
  logic [CNT_W-1:0]   frame_cnt_q;
  logic               armed_q;
  logic [2:0]         eaten_q, eaten_d;
  logic [SUM_W-1:0]   pop, sum;
  logic [NUM_OF_FRUITS-1:0] hit, fire, pulse;

  assign hit = {NUM_OF_FRUITS{monkeyDrawingRequest & armed_q}} & fruitDrawingRequest & drawFruit;

  for (genvar i = 0; i < NUM_OF_FRUITS; i++) begin : g_cell
    fruit_hit_cell u_cell (
      .clk     (clk),
      .reset   (reset),
      .sof_i   (startOfFrame),
      .hit_i   (hit[i]),
      .fire_o  (fire[i]),
      .pulse_o (pulse[i])
    );
  end

  // The count advances on the same edge that launches the pulses.
  always_comb begin
    pop = '0;
    for (int i = 0; i < NUM_OF_FRUITS; i++) begin
      pop = pop + SUM_W'(fire[i]);
    end
    sum     = SUM_W'(eaten_q) + pop;
    eaten_d = (sum > SUM_W'(EATEN_MAX)) ? 3'(EATEN_MAX) : sum[2:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= WAIT_ARM;
      frame_cnt_q <= '0;
      armed_q     <= 1'b0;
    end else begin
      case (state_q)
        WAIT_ARM: begin
          if (startOfFrame) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
            if (frame_cnt_q == CNT_W'(ARM_FRAMES - 1)) begin
              state_q <= ACTIVE;
              armed_q <= 1'b1;
            end
          end
        end
        ACTIVE: ;
        default: begin
          state_q <= WAIT_ARM;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) eaten_q <= 3'd0;
    else       eaten_q <= eaten_d;
  end

  assign monkeyCollision = pulse;
  assign eatenCount      = eaten_q;
  assign armed           = armed_q;

endmodule
